cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the Vedic multiplier datapath. It replaces the fixed 16-bit ripple-of-CLA4 adder in partial-product accumulation, where wide sums need registered carry chains to meet timing. Operands are split into 4-bit lookahead groups, and a configurable number of groups is evaluated per pipeline stage. The inter-stage group carry is registered, and operands and partial sums are skewed so results stay aligned. A valid/ready handshake with full-pipeline stall lets the multiplier back-pressure the adder.

## Interface
- WIDTH, 16: operand/sum width; must be a multiple of 4*GROUPS_PER_STAGE.
- GROUPS_PER_STAGE, 1: 4-bit CLA groups evaluated per pipeline stage. STAGES = WIDTH/(4*GROUPS_PER_STAGE).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  adder accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- **Effective operands:** b_eff = sub ? ~b : b; c0 = sub ? 1 : cin. Both are latched at acceptance.
- **Stage k (0..STAGES-1):** computes groups k*G .. k*G+G-1, where G = GROUPS_PER_STAGE.
  - Each group computes G = A&B and P = A^B.
  - Group carries are full lookahead within the group.
  - Groups within a stage chain their carries combinationally.
- **Stage k+1 carry-in:** the registered carry-out of stage k.
- **Skew registers:**
  - Operand slices for stages > k travel through registers.
  - Completed sum slices travel forward alongside.
  - Result bits leave the last stage aligned.
- **Overflow:** the last stage also registers the carry into bit WIDTH-1 to form ovf.
- **Flow control:**
  - advance = ~out_valid | out_ready; in_ready = advance.
  - On advance, every stage register loads from its predecessor. Stage 0 loads {in_valid, operands}.
  - When advance=0, all stage registers, including output, hold.
  - Bubbles are not collapsed: a stalled pipe stalls entirely.
- **Handshake rules:**
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - Results leave in acceptance order; none are dropped or duplicated.
- **Simultaneous transfers:** accept and emit in the same cycle is legal and required for full throughput (1 result/cycle).
- **in_valid=0 while advancing:** a bubble (valid=0) enters stage 0. Data registers may update, but out_valid for that slot is 0.

## Timing
- **Reset (rst=1 at an edge):**
  - All per-stage valid bits and out_valid clear to 0.
  - sum, cout and ovf clear to 0.
  - In-flight operations are discarded.
  - in_ready reads 1 the cycle after reset.
- **Latency:** an operand accepted at edge t produces out_valid=1 with its result after edge t+STAGES, provided no stall occurs. Default (16, 1): 4 cycles. (16, 2): 2 cycles. (16, 4): 1 cycle.
- **Stall effect:** each cycle with advance=0 adds one cycle to the latency of every in-flight item.
- **Output stability:** sum, cout and ovf are stable while out_valid=1 and out_ready=0.
- **Combinational paths:**
  - in_ready depends combinationally on out_ready (one gate).
  - There is no combinational path from a, b, cin or sub to any output.
- **Reset mid-operation:** takes priority over advance. A transfer-in coinciding with rst=1 is dropped.
- **Wrap-around:** sum is modulo 2^WIDTH. 0xFFFF+0x0001 wraps to 0x0000 with cout=1.

## Test plan
- **Basic add:** default params. a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1 → 4 cycles later sum=0x5555, cout=0, ovf=0, out_valid for exactly 1 cycle.
- **Carry across all groups:** 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then 0x7FFF+0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- **Subtract:** a=0x0003, b=0x0005, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- **Back-pressure:** 6 back-to-back inputs (i+1)*0x0101 + 0x0001, out_ready held low for cycles 5-7 → in_ready low during the stall, outputs hold the first result, all 6 sums emerge in order with no loss or duplication; throughput 1/cycle when out_ready=1.
- **Reset mid-stream:** 3 items in flight, assert rst one cycle → out_valid=0 and sum=0 next cycle, no stale item ever appears, a new input returns a correct result after 4 cycles.
- **Parameter sweep:** random a/b/cin/sub against a reference model for (WIDTH, G) = (16,1), (16,2), (32,2), (32,8) → results match, latency equals STAGES (4, 2, 4, 1 respectively).

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Rank 0 latches the operands; stage k adds slice k from rank k into rank k+1.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int G = GROUPS_PER_STAGE;
  localparam int SW = 4 * G;
  localparam int STAGES = WIDTH / SW;
  logic [STAGES:0]   r_v;
  logic [STAGES:0]   r_c;
  logic [WIDTH-1:0]  r_a [0:STAGES-1];
  logic [WIDTH-1:0]  r_b [0:STAGES-1];
  logic [WIDTH-1:0]  r_s [0:STAGES];
  logic              r_ovf;
  logic              w_adv;
  logic [WIDTH-1:0]  w_sum;
  logic [STAGES-1:0] w_co;
  logic              w_cm;
  assign w_adv = ~r_v[STAGES] | out_ready;
  assign in_ready = w_adv;
  assign out_valid = r_v[STAGES];
  assign sum = r_s[STAGES];
  assign cout = r_c[STAGES];
  assign ovf = r_ovf;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [G:0] w_c;
    assign w_c[0] = r_c[k];
    assign w_co[k] = w_c[G];
    for (genvar j = 0; j < G; j++) begin : g_grp
      localparam int L = k * SW + j * 4;
      logic [3:0] w_g, w_p;
      logic [4:0] w_k;
      assign w_g = r_a[k][L+:4] & r_b[k][L+:4];
      assign w_p = r_a[k][L+:4] ^ r_b[k][L+:4];
      assign w_k[0] = w_c[j];
      assign w_k[1] = w_g[0] | (w_p[0] & w_k[0]);
      assign w_k[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & w_k[0]);
      assign w_k[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & w_k[0]);
      assign w_k[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0])
                    | (&w_p & w_k[0]);
      assign w_sum[L+:4] = w_p ^ w_k[3:0];
      assign w_c[j+1] = w_k[4];
      // the top group also exposes the carry into the MSB for overflow
      if (L + 4 == WIDTH) begin : g_msb
        assign w_cm = w_k[3];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      r_s[STAGES] <= '0;
      r_c[STAGES] <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_v <= {r_v[STAGES-1:0], in_valid};
      r_a[0] <= a;
      r_b[0] <= sub ? ~b : b;
      r_c[0] <= sub | cin;
      r_s[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        r_s[k+1] <= r_s[k];
        r_s[k+1][k*SW+:SW] <= w_sum[k*SW+:SW];
        r_c[k+1] <= w_co[k];
      end
      r_ovf <= w_cm ^ w_co[STAGES-1];
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed checks of cla_pipe_adder plus a latency/result sweep
// over several (WIDTH, GROUPS_PER_STAGE) configurations.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst, in_valid, cin, sub, out_ready;
  logic [31:0] a, b;
  logic in_ready, out_valid, cout, ovf;
  logic [15:0] sum;
  logic rdy2, ov2, co2, of2, rdy3, ov3, co3, of3, rdy4, ov4, co4, of4;
  logic [15:0] s2;
  logic [31:0] s3, s4;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cla_pipe_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));
  cla_pipe_adder #(.WIDTH(16), .GROUPS_PER_STAGE(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(1'b1), .sum(s2), .cout(co2), .ovf(of2));
  cla_pipe_adder #(.WIDTH(32), .GROUPS_PER_STAGE(2)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov3), .out_ready(1'b1), .sum(s3), .cout(co3), .ovf(of3));
  cla_pipe_adder #(.WIDTH(32), .GROUPS_PER_STAGE(8)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(1'b1), .sum(s4), .cout(co4), .ovf(of4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {ovf, cout, sum} from plain wide arithmetic on the effective operands
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s);
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [63:0] xe = {32'd0, x} & m;
    logic [63:0] be = (s ? ~{32'd0, y} : {32'd0, y}) & m;
    logic [63:0] t = xe + be + {63'd0, s | ci};
    logic [63:0] r = t & m;
    logic of = (xe[w-1] == be[w-1]) && (r[w-1] != xe[w-1]);
    return {of, t[w], r[31:0]};
  endfunction

  task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic s, input logic [15:0] es, input logic ec, input logic eo);
    a = {16'd0, x};
    b = {16'd0, y};
    cin = ci;
    sub = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk({tag, "_early"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    tick();
    chk({tag, "_once"}, out_valid, 0);
  endtask

  logic [15:0] exp_q [6];
  logic [31:0] va [5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000003, 32'h12345678, 32'h80008000};
  logic [31:0] vb [5] = '{32'h00000001, 32'h00000000, 32'h00000005, 32'h9ABCDEF0, 32'h00010001};
  logic        vc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int sent, recv, seen, l2, l3, l4;
    logic [17:0] r2;
    logic [33:0] r3, r4, m;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;
    tick();
    run_one("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("cin_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_neg", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    // back-pressure: six items back to back, out_ready low for cycles 5..7
    for (int i = 0; i < 6; i++) exp_q[i] = 16'((i + 1) * 16'h0101 + 16'h0001 + 16'h1000);
    sent = 0;
    recv = 0;
    for (int c = 0; c < 30 && recv < 6; c++) begin
      in_valid = (sent < 6);
      a = 32'((sent + 1) * 16'h0101 + 16'h0001) & 32'hFFFF;
      b = 32'h1000;
      cin = 1'b0;
      sub = 1'b0;
      out_ready = !(c >= 5 && c <= 7);
      #1;
      if (c >= 5 && c <= 7) begin
        chk("bp_stall_ready", in_ready, 0);
        chk("bp_hold", sum, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        chk("bp_sum", sum, exp_q[recv]);
        chk("bp_cycle", 64'(c), 64'(8 + recv));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 64'(recv), 6);
    // reset with three items in flight
    a = 32'h1111;
    b = 32'h1111;
    in_valid = 1'b1;
    tick();
    a = 32'h2222;
    tick();
    a = 32'h3333;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    seen = 0;
    repeat (6) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mid_rst_stale", 64'(seen), 0);
    run_one("after_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
    // configuration sweep: latency and result per instance
    for (int v = 0; v < 5; v++) begin
      a = va[v];
      b = vb[v];
      cin = vc[v];
      sub = vs[v];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      l2 = 0;
      l3 = 0;
      l4 = 0;
      r2 = '0;
      r3 = '0;
      r4 = '0;
      for (int t = 1; t <= 5; t++) begin
        tick();
        if (ov2 && l2 == 0) begin l2 = t; r2 = {of2, co2, s2}; end
        if (ov3 && l3 == 0) begin l3 = t; r3 = {of3, co3, s3}; end
        if (ov4 && l4 == 0) begin l4 = t; r4 = {of4, co4, s4}; end
      end
      m = model(16, va[v], vb[v], vc[v], vs[v]);
      chk("sw16_2_lat", 64'(l2), 2);
      chk("sw16_2_res", r2, {m[33:32], m[15:0]});
      chk("sw32_2_lat", 64'(l3), 4);
      chk("sw32_2_res", r3, model(32, va[v], vb[v], vc[v], vs[v]));
      chk("sw32_8_lat", 64'(l4), 1);
      chk("sw32_8_res", r4, model(32, va[v], vb[v], vc[v], vs[v]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
